pad_draw_ctrl: RTL and testbench



---
 rtl/pad_draw_ctrl.sv | 213 +++++++++++++++++++++
 tb/tb_pad_draw_ctrl.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pad_draw_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pad_draw_ctrl
// Brief    : Rasterises NUM_PADS square pads into a framebuffer pixel port and
//            performs timed highlight/restore redraws. Optional macro
//            PAD_BORDER_EN draws each pad's outer ring in BORDER_COLOR.
// Revision : 1.0 - initial release
// ============================================================================
module pad_draw_ctrl #(
    parameter int         NUM_PADS     = 4,
    parameter int         PAD_SIZE     = 8,
    parameter int         PAD_GAP      = 4,
    parameter int         ORIGIN_X     = 16,
    parameter int         ORIGIN_Y     = 40,
    parameter int         XW           = 8,
    parameter int         YW           = 7,
    parameter int         IDXW         = 2,
    parameter int         HOLD_CYCLES  = 1000,
    parameter logic [2:0] BASE_COLOR   = 3'b111,
    parameter logic [2:0] HL_COLOR     = 3'b010,
    parameter logic [2:0] BORDER_COLOR = 3'b001
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic            hl_req,
    input  logic [IDXW-1:0] hl_pad,
    output logic            hl_busy,
    output logic            init_done,
    output logic [XW-1:0]   out_x,
    output logic [YW-1:0]   out_y,
    output logic [2:0]      out_color,
    output logic            plot
);

    localparam int c_pw    = (PAD_SIZE > 2) ? $clog2(PAD_SIZE) : 1;
    localparam int c_pitch = PAD_SIZE + PAD_GAP;
    localparam int c_hw    = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam int c_pix_w = XW + YW + 3;

    localparam logic [c_pw-1:0] c_last_px   = c_pw'(PAD_SIZE - 1);
    localparam logic [IDXW-1:0] c_last_pad  = IDXW'(NUM_PADS - 1);
    localparam logic [IDXW:0]   c_num_pads  = (IDXW+1)'(NUM_PADS);
    localparam logic [c_hw-1:0] c_hold_load = c_hw'((HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0);

`ifdef PAD_BORDER_EN
    localparam bit c_border_en = 1'b1;
`else
    localparam bit c_border_en = 1'b0;
`endif

    // Layout sanity: every pixel must be representable on the output port.
    generate
        if (ORIGIN_X + (NUM_PADS - 1) * c_pitch + PAD_SIZE > (1 << XW)) begin : g_x_overflow
            $error("pad_draw_ctrl: pad row exceeds the XW coordinate range");
        end
        if (ORIGIN_Y + PAD_SIZE > (1 << YW)) begin : g_y_overflow
            $error("pad_draw_ctrl: pad row exceeds the YW coordinate range");
        end
        if (NUM_PADS < 1 || NUM_PADS > (1 << IDXW)) begin : g_idx_range
            $error("pad_draw_ctrl: NUM_PADS must be 1..2**IDXW");
        end
        if (PAD_SIZE < 2) begin : g_size_range
            $error("pad_draw_ctrl: PAD_SIZE must be at least 2");
        end
    endgenerate

    typedef enum logic [2:0] {
        INIT_DRAW  = 3'd0,
        READY      = 3'd1,
        HL_DRAW    = 3'd2,
        HL_HOLD    = 3'd3,
        HL_RESTORE = 3'd4
    } state_t;

    state_t               r_state;
    logic [c_pw-1:0]      r_px;
    logic [c_pw-1:0]      r_py;
    logic [IDXW-1:0]      r_pad;
    logic [c_hw-1:0]      r_hold;
    logic [c_pix_w-1:0]   r_pix;
    logic                 r_plot;
    logic                 r_busy;
    logic                 r_init_done;

    logic                 w_px_last;
    logic                 w_pix_last;
    logic [c_pw-1:0]      w_adv_px;
    logic [c_pw-1:0]      w_adv_py;
    logic [IDXW-1:0]      w_adv_pad;
    logic                 w_req_ok;

    // Raster successor of the pixel currently on the port; pad steps only in the init sweep.
    always_comb begin
        w_px_last  = (r_px == c_last_px);
        w_pix_last = w_px_last && (r_py == c_last_px);
        w_adv_px   = w_px_last ? '0 : r_px + 1'b1;
        w_adv_py   = w_px_last ? (w_pix_last ? '0 : r_py + 1'b1) : r_py;
        w_adv_pad  = w_pix_last ? r_pad + 1'b1 : r_pad;
        w_req_ok   = hl_req && ({1'b0, hl_pad} < c_num_pads);
    end

    // Low bits of modular arithmetic equal the low bits of the full-precision sum.
    function automatic logic [c_pix_w-1:0] f_pix(input logic [IDXW-1:0] pad,
                                                 input logic [c_pw-1:0] px,
                                                 input logic [c_pw-1:0] py,
                                                 input logic [2:0]      fill);
        logic [XW-1:0] x;
        logic [YW-1:0] y;
        logic          border;
        x      = XW'(ORIGIN_X) + XW'(c_pitch) * XW'(pad) + XW'(px);
        y      = YW'(ORIGIN_Y) + YW'(py);
        border = c_border_en && (px == '0 || px == c_last_px || py == '0 || py == c_last_px);
        return {x, y, border ? BORDER_COLOR : fill};
    endfunction

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= INIT_DRAW;
            r_px        <= '0;
            r_py        <= '0;
            r_pad       <= '0;
            r_hold      <= '0;
            r_pix       <= '0;
            r_plot      <= 1'b0;
            r_busy      <= 1'b1;
            r_init_done <= 1'b0;
        end else begin
            unique case (r_state)
                INIT_DRAW: begin
                    if (!r_plot) begin
                        r_pix  <= f_pix(r_pad, r_px, r_py, BASE_COLOR);
                        r_plot <= 1'b1;
                    end else if (w_pix_last && r_pad == c_last_pad) begin
                        r_state     <= READY;
                        r_plot      <= 1'b0;
                        r_busy      <= 1'b0;
                        r_init_done <= 1'b1;
                    end else begin
                        r_px  <= w_adv_px;
                        r_py  <= w_adv_py;
                        r_pad <= w_adv_pad;
                        r_pix <= f_pix(w_adv_pad, w_adv_px, w_adv_py, BASE_COLOR);
                    end
                end
                READY: begin
                    if (w_req_ok) begin
                        r_state <= HL_DRAW;
                        r_pad   <= hl_pad;
                        r_px    <= '0;
                        r_py    <= '0;
                        r_pix   <= f_pix(hl_pad, '0, '0, HL_COLOR);
                        r_plot  <= 1'b1;
                        r_busy  <= 1'b1;
                    end else begin
                        r_plot  <= 1'b0;
                    end
                end
                HL_DRAW: begin
                    if (w_pix_last) begin
                        r_px <= '0;
                        r_py <= '0;
                        if (HOLD_CYCLES == 0) begin
                            r_state <= HL_RESTORE;
                            r_pix   <= f_pix(r_pad, '0, '0, BASE_COLOR);
                        end else begin
                            r_state <= HL_HOLD;
                            r_hold  <= c_hold_load;
                            r_plot  <= 1'b0;
                        end
                    end else begin
                        r_px  <= w_adv_px;
                        r_py  <= w_adv_py;
                        r_pix <= f_pix(r_pad, w_adv_px, w_adv_py, HL_COLOR);
                    end
                end
                HL_HOLD: begin
                    if (r_hold == '0) begin
                        r_state <= HL_RESTORE;
                        r_pix   <= f_pix(r_pad, r_px, r_py, BASE_COLOR);
                        r_plot  <= 1'b1;
                    end else begin
                        r_hold  <= r_hold - 1'b1;
                    end
                end
                HL_RESTORE: begin
                    if (w_pix_last) begin
                        r_state <= READY;
                        r_plot  <= 1'b0;
                        r_busy  <= 1'b0;
                    end else begin
                        r_px  <= w_adv_px;
                        r_py  <= w_adv_py;
                        r_pix <= f_pix(r_pad, w_adv_px, w_adv_py, BASE_COLOR);
                    end
                end
                default: begin
                    r_state <= INIT_DRAW;
                    r_plot  <= 1'b0;
                    r_busy  <= 1'b1;
                end
            endcase
        end
    end

    assign out_x     = r_pix[c_pix_w-1 -: XW];
    assign out_y     = r_pix[3 +: YW];
    assign out_color = r_pix[2:0];
    assign plot      = r_plot;
    assign hl_busy   = r_busy;
    assign init_done = r_init_done;

endmodule
`default_nettype wire

// File: tb/tb_pad_draw_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pad_draw_ctrl
// Brief    : Self-checking bench for pad_draw_ctrl with a timeline reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pad_draw_ctrl;

    localparam int         N    = 4;
    localparam int         S    = 4;
    localparam int         G    = 2;
    localparam int         OX   = 10;
    localparam int         OY   = 20;
    localparam int         H    = 8;
    localparam int         IDXW = 3;
    localparam int         XW   = 8;
    localparam int         YW   = 7;
    localparam logic [2:0] BASE = 3'b111;
    localparam logic [2:0] HLC  = 3'b010;
    localparam logic [2:0] BRD  = 3'b001;
    localparam int         OPLEN = 2 * S * S + H;

    logic            clock   = 1'b0;
    logic            reset_n = 1'b0;
    logic            hl_req  = 1'b0;
    logic [IDXW-1:0] hl_pad  = '0;
    logic            hl_busy;
    logic            init_done;
    logic [XW-1:0]   out_x;
    logic [YW-1:0]   out_y;
    logic [2:0]      out_color;
    logic            plot;

    pad_draw_ctrl #(
        .NUM_PADS(N), .PAD_SIZE(S), .PAD_GAP(G), .ORIGIN_X(OX), .ORIGIN_Y(OY),
        .XW(XW), .YW(YW), .IDXW(IDXW), .HOLD_CYCLES(H),
        .BASE_COLOR(BASE), .HL_COLOR(HLC), .BORDER_COLOR(BRD)
    ) u_dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .hl_req    (hl_req),
        .hl_pad    (hl_pad),
        .hl_busy   (hl_busy),
        .init_done (init_done),
        .out_x     (out_x),
        .out_y     (out_y),
        .out_color (out_color),
        .plot      (plot)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;
    int cycle  = 0;

    // Reference model: position within the init sweep or within a highlight operation.
    int            m_edges;
    int            m_op_t;
    int            m_op_pad;
    logic          e_plot, e_busy, e_init;
    logic [XW-1:0] e_x;
    logic [YW-1:0] e_y;
    logic [2:0]    e_col;

    function automatic logic [2:0] m_color(input int px, input int py, input logic [2:0] fill);
`ifdef PAD_BORDER_EN
        if (px == 0 || px == S - 1 || py == 0 || py == S - 1) return BRD;
`endif
        if (px < 0 || py < 0) return 3'b000;
        return fill;
    endfunction

    task automatic m_pixel(input int pad, input int k, input logic [2:0] fill);
        int px, py;
        px     = k % S;
        py     = k / S;
        e_plot = 1'b1;
        e_x    = XW'(OX + pad * (S + G) + px);
        e_y    = YW'(OY + py);
        e_col  = m_color(px, py, fill);
    endtask

    task automatic model_reset();
        m_edges = 0;
        m_op_t  = -1;
        e_plot  = 1'b0;
        e_busy  = 1'b1;
        e_init  = 1'b0;
        e_x     = '0;
        e_y     = '0;
        e_col   = '0;
    endtask

    task automatic model_edge();
        if (m_edges <= N * S * S) begin
            m_edges++;
            if (m_edges <= N * S * S) begin
                m_pixel((m_edges - 1) / (S * S), (m_edges - 1) % (S * S), BASE);
            end else begin
                e_plot = 1'b0;
                e_busy = 1'b0;
                e_init = 1'b1;
            end
        end else if (m_op_t >= 0) begin
            m_op_t++;
            if (m_op_t == OPLEN) begin
                m_op_t = -1;
                e_plot = 1'b0;
                e_busy = 1'b0;
            end else if (m_op_t < S * S) begin
                m_pixel(m_op_pad, m_op_t, HLC);
            end else if (m_op_t < S * S + H) begin
                e_plot = 1'b0;
            end else begin
                m_pixel(m_op_pad, m_op_t - S * S - H, BASE);
            end
        end else if (hl_req && int'(hl_pad) < N) begin
            m_op_t   = 0;
            m_op_pad = int'(hl_pad);
            e_busy   = 1'b1;
            m_pixel(m_op_pad, 0, HLC);
        end else begin
            e_plot = 1'b0;
        end
    endtask

    task automatic check_outputs();
        checks++;
        if ({plot, hl_busy, init_done, out_x, out_y, out_color} !==
            {e_plot, e_busy, e_init, e_x, e_y, e_col}) begin
            errors++;
            $display("FAIL outputs cycle %0d: got plot=%b busy=%b done=%b x=%0d y=%0d col=%b, required plot=%b busy=%b done=%b x=%0d y=%0d col=%b",
                     cycle, plot, hl_busy, init_done, out_x, out_y, out_color,
                     e_plot, e_busy, e_init, e_x, e_y, e_col);
        end
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        cycle++;
        model_edge();
        #1;
        check_outputs();
    endtask

    typedef struct {
        logic [IDXW-1:0] pad;
        int              plots;
        int              busy;
        int              xmin;
        int              xmax;
    } hl_vec_t;

    hl_vec_t vecs[7];

    initial begin
        int plots, busy, xmin, xmax, lows, run, maxrun;
        logic [2:0] first_col;

        vecs[0] = '{3'd0, 32, 40, 10, 13};
        vecs[1] = '{3'd2, 32, 40, 22, 25};
        vecs[2] = '{3'd5,  0,  0, -1, -1};
        vecs[3] = '{3'd3, 32, 40, 28, 31};
        vecs[4] = '{3'd7,  0,  0, -1, -1};
        vecs[5] = '{3'd1, 32, 40, 16, 19};
        vecs[6] = '{3'd4,  0,  0, -1, -1};
`ifdef PAD_BORDER_EN
        first_col = BRD;
`else
        first_col = BASE;
`endif

        // Reset state
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        check_outputs();
        @(negedge clock);
        reset_n = 1'b1;

        // Initial draw with landmark pixels
        for (int i = 1; i <= N * S * S + 1; i++) begin
            step();
            if (i == 1) begin
                check("first_x", int'(out_x), 10);
                check("first_y", int'(out_y), 20);
                check("first_color", int'(out_color), int'(first_col));
            end
            if (i == S * S + 1) check("pad1_start_x", int'(out_x), 16);
            if (i == N * S * S) begin
                check("last_x", int'(out_x), 31);
                check("last_y", int'(out_y), 23);
                check("done_before_end", int'(init_done), 0);
            end
            if (i == N * S * S + 1) begin
                check("init_done_rise", int'(init_done), 1);
                check("ready_not_busy", int'(hl_busy), 0);
            end
        end

        // Table of single highlight requests, valid and out-of-range
        foreach (vecs[v]) begin
            plots = 0; busy = 0; xmin = 1000; xmax = -1;
            hl_req = 1'b1;
            hl_pad = vecs[v].pad;
            for (int c = 0; c < OPLEN + 5; c++) begin
                step();
                hl_req = 1'b0;
                if (hl_busy) busy++;
                if (plot) begin
                    plots++;
                    if (int'(out_x) < xmin) xmin = int'(out_x);
                    if (int'(out_x) > xmax) xmax = int'(out_x);
                end
            end
            if (xmin == 1000) xmin = -1;
            check($sformatf("vec%0d_plots", v), plots, vecs[v].plots);
            check($sformatf("vec%0d_busy", v), busy, vecs[v].busy);
            check($sformatf("vec%0d_xmin", v), xmin, vecs[v].xmin);
            check($sformatf("vec%0d_xmax", v), xmax, vecs[v].xmax);
        end

        // Second pulse landing in the hold window is dropped
        plots = 0;
        hl_req = 1'b1; hl_pad = 3'd0;
        step();
        hl_req = 1'b0;
        if (plot) plots++;
        for (int c = 1; c < 60; c++) begin
            if (c == 20) begin hl_req = 1'b1; hl_pad = 3'd3; end
            step();
            hl_req = 1'b0;
            if (plot) plots++;
        end
        check("hold_pulse_plots", plots, 32);

        // Request held high: one idle READY cycle between back-to-back operations
        lows = 0; run = 0; maxrun = 0;
        hl_req = 1'b1; hl_pad = 3'd1;
        for (int c = 0; c < 3 * (OPLEN + 1) + 7; c++) begin
            step();
            if (!hl_busy) begin
                lows++; run++;
                if (run > maxrun) maxrun = run;
            end else begin
                run = 0;
            end
        end
        hl_req = 1'b0;
        check("held_low_cycles", lows, 3);
        check("held_low_run", maxrun, 1);
        repeat (OPLEN + 2) step();

        // Asynchronous reset in the middle of a highlight draw
        hl_req = 1'b1; hl_pad = 3'd2;
        step();
        hl_req = 1'b0;
        repeat (5) step();
        #2;
        reset_n = 1'b0;
        #1;
        model_reset();
        check_outputs();
        @(negedge clock);
        reset_n = 1'b1;
        for (int i = 1; i <= N * S * S + 1; i++) begin
            step();
            if (i == N * S * S) check("reinit_done_low", int'(init_done), 0);
            if (i == N * S * S + 1) check("reinit_done_high", int'(init_done), 1);
        end

        // Randomised requests against the model
        for (int c = 0; c < 600; c++) begin
            hl_req = ($urandom_range(0, 7) == 0);
            hl_pad = IDXW'($urandom_range(0, 7));
            step();
        end
        hl_req = 1'b0;
        repeat (OPLEN + 2) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
